rbs64_seq: RTL
==============

Name: rbs64_seq

Overview:
- Multi-cycle 64-bit ripple-borrow subtractor; the inverse-direction companion to the registered RCA64 adder in the datapath.
- Computes diff = op1 - op2 and borrow-out serially, one SLICE-bit chunk per clock, least-significant chunk first.
- Uses a start/busy/done handshake so a controller can issue operands and collect results.

Parameters:
- WIDTH, 64, operand/result width in bits.
- SLICE, 16, bits subtracted per clock. WIDTH must be a multiple of SLICE; the RTL contains an elaboration-time check that fails otherwise.
- NSLICE, WIDTH/SLICE (derived, localparam), number of compute cycles.

Ports:
- clock  input  1  system clock; rising-edge active.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  request; sampled on a rising clock edge in IDLE or DONE.
- op1  input  WIDTH  minuend; captured on the edge start is accepted.
- op2  input  WIDTH  subtrahend; captured with op1.
- diff  output  WIDTH  registered result, op1 - op2 mod 2^WIDTH.
- brout  output  1  registered borrow-out; 1 iff op1 < op2 (unsigned).
- busy  output  1  high while slices are being computed (state RUN).
- done  output  1  one-cycle pulse; diff and brout are valid from this cycle onward.

Behaviour:
- Reset (reset=0, asynchronous) forces state=IDLE and clears diff, brout, busy, done, slice counter, internal borrow and working registers to 0.
- Reset asserted mid-operation aborts the operation; no done pulse is produced for it.
- States are IDLE, RUN and DONE.
- IDLE:
  - busy=0, done=0.
  - start=1 at an edge: capture op1/op2 into working registers, counter=0, borrow=0, next state RUN.
- RUN (busy=1):
  - Each edge computes chunk k = counter: {b, d} = A[k] - B[k] - borrow.
  - d is written into working-diff chunk k; borrow is updated to b; counter increments.
  - On the edge processing k = NSLICE-1: load diff from working-diff (with the final chunk), load brout = b, assert done, next state DONE.
  - start is ignored in RUN. Operands captured at acceptance are unaffected by later op1/op2 changes.
- DONE (busy=0, done=1 for exactly one cycle):
  - start=1: accepted exactly as in IDLE; next state RUN (back-to-back operation).
  - Otherwise: next state IDLE.
- Latency: start accepted at edge t; busy=1 in cycles t..t+NSLICE-1; done=1 and result valid after edge t+NSLICE.
- Maximum throughput is one result per NSLICE+1 cycles.
- diff and brout hold their value until the next completion or reset. They never show partial results.
- Arithmetic is unsigned modulo 2^WIDTH; the borrow chains between chunks via the internal borrow register.

Optional Feature:
- Macro: RBS64_OVF_FLAG_EN.
- Defined:
  - Adds output port ovf (1 bit, registered). It is loaded at completion with the signed two's-complement overflow: (op1[MSB] != op2[MSB]) && (diff[MSB] != op1[MSB]).
  - ovf resets to 0 and holds like diff.
- Undefined:
  - Port ovf is absent; no sign bits are retained.
  - Behaviour is otherwise identical.

Test Plan:
- Basic: op1=64'h1234_ffff_dfff_eeee, op2=64'hdddd_dddd_dddd_dddd, start pulse -> done exactly 4 cycles after acceptance; diff=64'h3457_2222_0222_1111, brout=1; busy high exactly 4 cycles.
- Cross-slice borrow: op1=64'h0000_0000_0001_0000, op2=64'h1 -> diff=64'h0000_0000_0000_FFFF, brout=0. Also op1=0, op2=1 -> diff=64'hFFFF_FFFF_FFFF_FFFF, brout=1.
- Equal operands: op1=op2=64'hA5A5_A5A5_A5A5_A5A5 -> diff=0, brout=0. With RBS64_OVF_FLAG_EN: op1=64'h8000_0000_0000_0000, op2=1 -> diff=64'h7FFF_FFFF_FFFF_FFFF, ovf=1.
- Ignored start: start held high through RUN with op1/op2 changed after acceptance -> result matches the first operands only; the start high in the DONE cycle launches the second operation; exactly two done pulses, each 1 cycle wide.
- Reset mid-op: drive reset=0 two cycles after acceptance, off-edge -> busy, done, diff, brout go to 0 immediately without a clock edge. After release, no done pulse appears until a new start.
- Result hold: after done, change op1/op2 with start=0 for 10 cycles -> diff and brout unchanged; busy=0, done=0.

Source files
------------

// File: rtl/rbs64_seq.sv
// ---------------------------------------------------------------------------
// rbs64_seq - multi-cycle ripple-borrow subtractor.
//
// Computes diff = op1 - op2 (unsigned, modulo 2^WIDTH) plus a borrow-out,
// SLICE bits per clock, least-significant chunk first. The borrow ripples
// between chunks through an internal register. A start/busy/done handshake
// lets a controller issue operands and collect the result.
//
// Optional feature macro: RBS64_OVF_FLAG_EN
//   When defined, adds output ovf, the signed two's-complement overflow
//   of the subtraction, loaded at completion and held like diff.
//
// Ports:
//   clock  in   rising-edge system clock
//   reset  in   asynchronous active-low reset (0 = in reset)
//   start  in   request, accepted on an edge while IDLE or DONE
//   op1    in   minuend, captured when start is accepted
//   op2    in   subtrahend, captured with op1
//   ovf    out  signed overflow flag (only with RBS64_OVF_FLAG_EN)
//   diff   out  registered result, op1 - op2
//   brout  out  registered borrow-out, 1 iff op1 < op2 (unsigned)
//   busy   out  high while chunks are being computed
//   done   out  one-cycle pulse; diff/brout valid from this cycle onward
// ---------------------------------------------------------------------------
module rbs64_seq #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
`ifdef RBS64_OVF_FLAG_EN
  output logic             ovf,
`endif
  output logic [WIDTH-1:0] diff,
  output logic             brout,
  output logic             busy,
  output logic             done
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  // Refuse to elaborate a configuration that cannot be split evenly.
  if ((WIDTH % SLICE) != 0) begin : gBadCfg
    $error("rbs64_seq: WIDTH must be a multiple of SLICE");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           stateQ, stateD;
  logic [WIDTH-1:0] aQ, aD;
  logic [WIDTH-1:0] bQ, bD;
  logic [WIDTH-1:0] wdiffQ, wdiffD;
  logic [CW-1:0]    cntQ, cntD;
  logic             borrowQ, borrowD;
  logic [WIDTH-1:0] diffQ, diffD;
  logic             broutQ, broutD;
`ifdef RBS64_OVF_FLAG_EN
  logic             ovfQ, ovfD;
`endif

  // Datapath for the current chunk.
  int               idx;
  logic [SLICE-1:0] aChunk, bChunk;
  logic [SLICE:0]   sub;
  logic [WIDTH-1:0] wdiffNew;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stateQ  <= IDLE;
      aQ      <= '0;
      bQ      <= '0;
      wdiffQ  <= '0;
      cntQ    <= '0;
      borrowQ <= 1'b0;
      diffQ   <= '0;
      broutQ  <= 1'b0;
`ifdef RBS64_OVF_FLAG_EN
      ovfQ    <= 1'b0;
`endif
    end else begin
      stateQ  <= stateD;
      aQ      <= aD;
      bQ      <= bD;
      wdiffQ  <= wdiffD;
      cntQ    <= cntD;
      borrowQ <= borrowD;
      diffQ   <= diffD;
      broutQ  <= broutD;
`ifdef RBS64_OVF_FLAG_EN
      ovfQ    <= ovfD;
`endif
    end
  end

  always_comb begin
    stateD  = stateQ;
    aD      = aQ;
    bD      = bQ;
    wdiffD  = wdiffQ;
    cntD    = cntQ;
    borrowD = borrowQ;
    diffD   = diffQ;
    broutD  = broutQ;
`ifdef RBS64_OVF_FLAG_EN
    ovfD    = ovfQ;
`endif

    // One chunk subtraction; bit SLICE of the result is the chunk borrow.
    idx      = int'(cntQ) * SLICE;
    aChunk   = aQ[idx +: SLICE];
    bChunk   = bQ[idx +: SLICE];
    sub      = {1'b0, aChunk} - {1'b0, bChunk} - {{SLICE{1'b0}}, borrowQ};
    wdiffNew = wdiffQ;
    wdiffNew[idx +: SLICE] = sub[SLICE-1:0];

    case (stateQ)
      IDLE, DONE: begin
        if (start) begin
          aD      = op1;
          bD      = op2;
          cntD    = '0;
          borrowD = 1'b0;
          stateD  = RUN;
        end else begin
          stateD  = IDLE;
        end
      end
      RUN: begin
        wdiffD  = wdiffNew;
        borrowD = sub[SLICE];
        cntD    = cntQ + 1'b1;
        // The last chunk goes straight into the visible result so that
        // diff/brout only ever change on completion.
        if (cntQ == LAST) begin
          diffD  = wdiffNew;
          broutD = sub[SLICE];
`ifdef RBS64_OVF_FLAG_EN
          ovfD   = (aQ[WIDTH-1] != bQ[WIDTH-1]) &&
                   (wdiffNew[WIDTH-1] != aQ[WIDTH-1]);
`endif
          cntD   = '0;
          stateD = DONE;
        end
      end
      default: stateD = IDLE;
    endcase
  end

  assign diff  = diffQ;
  assign brout = broutQ;
  assign busy  = (stateQ == RUN);
  assign done  = (stateQ == DONE);
`ifdef RBS64_OVF_FLAG_EN
  assign ovf   = ovfQ;
`endif

endmodule
